// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and constants for the memory-stage access controller.
package mem_access_ctrl_pkg;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Saturating counter of cycles spent waiting on the data memory.
module mem_access_ctrl_wait_timer
  import mem_access_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High during the enabled cycle whose edge brings the count to MAX_WAIT.
  assign o_expired = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory stage: runs X/M loads/stores against a req/done data memory and owns M/W.
//   state | meaning
//   IDLE  | no access outstanding; M/W follows X/M each cycle
//   WAIT  | request issued, waiting for mem_done (upstream stalled)
//   ERR   | unaligned access or timeout seen; frozen until reset
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              xm_memRead,
  input  logic              xm_memWriteEn,
  input  logic [DATA_W-1:0] xm_addr,
  input  logic [DATA_W-1:0] xm_wdata,
  input  logic              xm_writeEn,
  input  logic [SEL_W-1:0]  xm_writeRegSel,
  input  logic [DATA_W-1:0] xm_wbData,
  input  logic              xm_halt,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              mw_writeEn,
  output logic [SEL_W-1:0]  mw_writeRegSel,
  output logic [DATA_W-1:0] mw_memData,
  output logic [DATA_W-1:0] mw_wbData,
  output logic              mw_memRead,
  output logic              mw_halt,
  output logic              err
);

  typedef struct packed {
    logic              wen;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] wb;
    logic              rd;
    logic              halt;
  } mw_t;

  state_t            r_state;
  mw_t               r_mw;
  mw_t               r_pend;
  logic              r_wr;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_squash;
  logic              r_err;

  mw_t  w_xm;
  logic w_idle;
  logic w_in_wait;
  logic w_access;
  logic w_issue;
  logic w_unaligned;
  logic w_expired;

  // Combinational outputs are gated by rst so nothing leaks out during reset.
  assign w_idle      = rst && (r_state == ST_IDLE);
  assign w_in_wait   = (r_state == ST_WAIT);
  assign w_access    = xm_memRead || xm_memWriteEn;
  assign w_issue     = w_idle && w_access && !flush && !xm_addr[0];
  assign w_unaligned = w_idle && w_access && !flush && xm_addr[0];

  always_comb begin
    w_xm      = '0;
    w_xm.wen  = xm_writeEn;
    w_xm.sel  = xm_writeRegSel;
    w_xm.wb   = xm_wbData;
    w_xm.rd   = xm_memRead && !xm_memWriteEn;
    w_xm.halt = xm_halt;
  end

  mem_access_ctrl_wait_timer u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   ((r_state == ST_IDLE) || (w_in_wait && mem_done)),
    .i_en      (w_in_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mw     <= '0;
      r_pend   <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_squash <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_pend   <= w_xm;
            r_wr     <= xm_memWriteEn;
            r_addr   <= xm_addr;
            r_wdata  <= xm_wdata;
            r_squash <= 1'b0;
            r_state  <= ST_WAIT;
          end else if (w_unaligned) begin
            r_mw    <= '0;
            r_err   <= 1'b1;
            r_state <= ST_ERR;
          end else if (flush) begin
            r_mw <= '0;
          end else begin
            r_mw <= w_xm;
          end
        end
        ST_WAIT: begin
          if (mem_done) begin
            // A flush seen at any point during the access turns the result into a bubble.
            if (r_squash || flush) begin
              r_mw <= '0;
            end else begin
              r_mw      <= r_pend;
              r_mw.data <= r_pend.rd ? mem_rdata : '0;
            end
            r_squash <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_expired) begin
            r_mw    <= '0;
            r_err   <= 1'b1;
            r_state <= ST_ERR;
          end else if (flush) begin
            r_squash <= 1'b1;
          end
        end
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = w_issue;
  assign mem_wr    = w_issue ? xm_memWriteEn : r_wr;
  assign mem_addr  = w_issue ? xm_addr : r_addr;
  assign mem_wdata = w_issue ? xm_wdata : r_wdata;
  assign stall     = w_issue || w_unaligned || (w_in_wait && !mem_done) || (r_state == ST_ERR);

  assign mw_writeEn     = r_mw.wen;
  assign mw_writeRegSel = r_mw.sel;
  assign mw_memData     = r_mw.data;
  assign mw_wbData      = r_mw.wb;
  assign mw_memRead     = r_mw.rd;
  assign mw_halt        = r_mw.halt;
  assign err            = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, corner sequences, random transactions.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        xm_memRead, xm_memWriteEn;
  logic [15:0] xm_addr, xm_wdata, xm_wbData;
  logic        xm_writeEn, xm_halt;
  logic [2:0]  xm_writeRegSel;
  logic        mem_req, mem_wr, mem_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, mw_writeEn, mw_memRead, mw_halt, err;
  logic [2:0]  mw_writeRegSel;
  logic [15:0] mw_memData, mw_wbData;

  mem_access_ctrl #(.DATA_W(16), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .xm_memRead(xm_memRead), .xm_memWriteEn(xm_memWriteEn), .xm_addr(xm_addr),
    .xm_wdata(xm_wdata), .xm_writeEn(xm_writeEn), .xm_writeRegSel(xm_writeRegSel),
    .xm_wbData(xm_wbData), .xm_halt(xm_halt),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .stall(stall),
    .mw_writeEn(mw_writeEn), .mw_writeRegSel(mw_writeRegSel), .mw_memData(mw_memData),
    .mw_wbData(mw_wbData), .mw_memRead(mw_memRead), .mw_halt(mw_halt), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_seen = 0;
  int r0, occ, waitc, lat, fk, kind;
  logic released, rrd, rwr, rwen, rhalt, rfl, rsq, issue;
  logic [15:0] ra, rwd, rwb, rdv;
  logic [2:0] rsel;

  always @(negedge clk) if (mem_req) req_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic flush, rd, wr;
    logic [15:0] addr, wdata;
    logic wen;
    logic [2:0] sel;
    logic [15:0] wb;
    logic halt;
    logic e_stall, e_wen;
    logic [2:0] e_sel;
    logic [15:0] e_wb;
    logic e_halt;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_mw(input string t, input logic wen, input logic [2:0] sel,
                        input logic [15:0] md, input logic [15:0] wb, input logic rd, input logic halt);
    chk({t, "_wen"},  mw_writeEn, wen);
    chk({t, "_sel"},  mw_writeRegSel, sel);
    chk({t, "_md"},   mw_memData, md);
    chk({t, "_wb"},   mw_wbData, wb);
    chk({t, "_rd"},   mw_memRead, rd);
    chk({t, "_halt"}, mw_halt, halt);
  endtask

  task automatic set_xm(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic wen, input logic [2:0] sel, input logic [15:0] wb, input logic halt);
    xm_memRead = rd; xm_memWriteEn = wr; xm_addr = a; xm_wdata = wd;
    xm_writeEn = wen; xm_writeRegSel = sel; xm_wbData = wb; xm_halt = halt;
  endtask

  task automatic idle_inputs();
    set_xm(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    flush = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd5, 16'hA5A5, 1'b0, 1'b0, 1'b1, 3'd5, 16'hA5A5, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678, 1'b0, 3'd2, 16'h0F0F, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0F0F, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd3, 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 3'd6, 16'h4444, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0043, 16'hBEEF, 1'b0, 3'd1, 16'h5555, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0, 1'b1, 3'd7, 16'hFFFF, 1'b1};

    // Reset with an aligned load already presented: nothing may escape.
    rst = 1'b0;
    idle_inputs();
    set_xm(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 3'd2, 16'h0, 1'b0);
    #2;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk_mw("rst", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); idle_inputs(); rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      set_xm(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wen,
             vecs[i].sel, vecs[i].wb, vecs[i].halt);
      flush = vecs[i].flush;
      @(negedge clk);
      chk("tbl_req", mem_req, 1'b0);
      chk("tbl_stall", stall, vecs[i].e_stall);
      tick();
      chk_mw("tbl", vecs[i].e_wen, vecs[i].e_sel, 16'h0, vecs[i].e_wb, 1'b0, vecs[i].e_halt);
      chk("tbl_err", err, 1'b0);
    end
    flush = 1'b0;

    // Load, done on the third cycle after the request.
    set_xm(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 3'd2, 16'h7777, 1'b0);
    r0 = req_seen;
    @(negedge clk);
    chk("ld_req", mem_req, 1'b1);
    chk("ld_wr", mem_wr, 1'b0);
    chk("ld_addr", mem_addr, 16'h0010);
    chk("ld_stall_req", stall, 1'b1);
    tick();
    occ = 1;
    for (int k = 1; k <= 6; k++) begin
      mem_done = (k == 3);
      mem_rdata = (k == 3) ? 16'hBEEF : 16'h0000;
      @(negedge clk);
      occ++;
      chk("ld_hold_addr", mem_addr, 16'h0010);
      released = !stall;
      tick();
      if (released) break;
    end
    idle_inputs();
    chk("ld_occupancy", occ, 4);
    chk_mw("ld", 1'b1, 3'd2, 16'hBEEF, 16'h7777, 1'b1, 1'b0);
    chk("ld_reqs", req_seen - r0, 1);

    // Store, done on the cycle after the request, then a back-to-back load.
    set_xm(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 3'd1, 16'h0BAD, 1'b0);
    r0 = req_seen;
    @(negedge clk);
    chk("st_req", mem_req, 1'b1);
    chk("st_wr", mem_wr, 1'b1);
    chk("st_addr", mem_addr, 16'h0020);
    chk("st_wdata", mem_wdata, 16'h1234);
    chk("st_stall", stall, 1'b1);
    tick();
    mem_done = 1'b1;
    @(negedge clk);
    chk("st_done_req", mem_req, 1'b0);
    chk("st_done_stall", stall, 1'b0);
    chk("st_hold_addr", mem_addr, 16'h0020);
    chk("st_hold_wdata", mem_wdata, 16'h1234);
    chk("st_hold_wr", mem_wr, 1'b1);
    tick();
    mem_done = 1'b0;
    set_xm(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 3'd5, 16'h0000, 1'b0);
    chk_mw("st", 1'b0, 3'd1, 16'h0, 16'h0BAD, 1'b0, 1'b0);
    chk("st_reqs", req_seen - r0, 1);
    @(negedge clk);
    chk("b2b_req", mem_req, 1'b1);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    chk("b2b_stall", stall, 1'b0);
    tick();
    idle_inputs();
    chk_mw("b2b", 1'b1, 3'd5, 16'h5A5A, 16'h0, 1'b1, 1'b0);

    // Flush while a store is outstanding.
    set_xm(1'b0, 1'b1, 16'h0044, 16'hCAFE, 1'b1, 3'd4, 16'h1111, 1'b1);
    @(negedge clk);
    chk("fl_req", mem_req, 1'b1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_stall1", stall, 1'b1);
    chk("fl_noreq", mem_req, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_stall2", stall, 1'b1);
    tick();
    mem_done = 1'b1;
    @(negedge clk);
    chk("fl_done_stall", stall, 1'b0);
    chk("fl_wr", mem_wr, 1'b1);
    chk("fl_addr", mem_addr, 16'h0044);
    tick();
    mem_done = 1'b0;
    set_xm(1'b1, 1'b0, 16'h0046, 16'h0000, 1'b1, 3'd6, 16'h0000, 1'b0);
    chk_mw("fl", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_next_req", mem_req, 1'b1);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h1357;
    @(negedge clk);
    tick();
    idle_inputs();
    chk_mw("fl_clr", 1'b1, 3'd6, 16'h1357, 16'h0, 1'b1, 1'b0);

    // Random instruction stream against a per-transaction model.
    r0 = req_seen;
    waitc = 0;
    for (int n = 0; n < 200; n++) begin
      kind  = $urandom_range(0, 3);
      rrd   = (kind == 1) || (kind == 3);
      rwr   = (kind == 2) || (kind == 3);
      ra    = 16'($urandom) & 16'hFFFE;
      rwd   = 16'($urandom);
      rwb   = 16'($urandom);
      rsel  = 3'($urandom);
      rwen  = 1'($urandom);
      rhalt = ($urandom_range(0, 15) == 0);
      rfl   = ($urandom_range(0, 7) == 0);
      lat   = $urandom_range(1, 6);
      fk    = (lat > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat - 1) : 0;
      rdv   = 16'($urandom);
      issue = (rrd || rwr) && !rfl;
      rsq   = (fk != 0);
      if (issue) waitc++;

      set_xm(rrd, rwr, ra, rwd, rwen, rsel, rwb, rhalt);
      flush = rfl;
      mem_done = !issue && ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      chk("rnd_req", mem_req, issue);
      chk("rnd_stall", stall, issue);
      if (issue) begin
        chk("rnd_addr", mem_addr, ra);
        chk("rnd_wr", mem_wr, rwr);
        chk("rnd_wdata", mem_wdata, rwd);
      end
      tick();
      flush = 1'b0; mem_done = 1'b0;
      if (issue) begin
        for (int k = 1; k <= lat; k++) begin
          flush = (k == fk);
          mem_done = (k == lat);
          mem_rdata = (k == lat) ? rdv : 16'($urandom);
          @(negedge clk);
          chk("rnd_wait_stall", stall, (k != lat));
          chk("rnd_wait_req", mem_req, 1'b0);
          chk("rnd_wait_addr", mem_addr, ra);
          tick();
        end
        flush = 1'b0; mem_done = 1'b0;
        if (rsq)
          chk_mw("rnd_sq", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        else
          chk_mw("rnd_acc", rwen, rsel, (rrd && !rwr) ? rdv : 16'h0, rwb, rrd && !rwr, rhalt);
      end else if (rfl) begin
        chk_mw("rnd_fl", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
      end else begin
        chk_mw("rnd_op", rwen, rsel, 16'h0, rwb, 1'b0, rhalt);
      end
    end
    chk("rnd_reqs", req_seen - r0, waitc);
    idle_inputs();

    // Timeout: aligned read that never completes.
    set_xm(1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1, 3'd1, 16'h0000, 1'b0);
    r0 = req_seen;
    @(negedge clk);
    chk("to_req", mem_req, 1'b1);
    tick();
    waitc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (err) break;
      waitc++;
      tick();
    end
    chk("to_wait_cycles", waitc, 15);
    chk("to_err", err, 1'b1);
    chk("to_stall", stall, 1'b1);
    mem_done = 1'b1;
    set_xm(1'b0, 1'b1, 16'h0070, 16'h0001, 1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("to_err_noreq", mem_req, 1'b0);
    chk("to_err_stall", stall, 1'b1);
    tick(); tick();
    mem_done = 1'b0;
    chk("to_reqs", req_seen - r0, 1);
    chk("to_err_sticky", err, 1'b1);
    chk_mw("to", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);

    @(negedge clk); rst = 1'b0; idle_inputs();
    @(negedge clk); rst = 1'b1;
    tick();
    chk("to_rst_err", err, 1'b0);

    // Unaligned access after a visible non-zero M/W.
    set_xm(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd7, 16'h9999, 1'b0);
    tick();
    set_xm(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 3'd3, 16'h2222, 1'b0);
    r0 = req_seen;
    @(negedge clk);
    chk("ua_req", mem_req, 1'b0);
    tick();
    chk("ua_err", err, 1'b1);
    chk("ua_stall", stall, 1'b1);
    chk_mw("ua", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("ua_reqs", req_seen - r0, 0);

    @(negedge clk); rst = 1'b0; idle_inputs();
    @(negedge clk); rst = 1'b1;
    tick();

    // mem_done in IDLE is ignored; then reset in the middle of a wait.
    set_xm(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd6, 16'h4321, 1'b0);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("idle_done_stall", stall, 1'b0);
    tick();
    mem_done = 1'b0;
    chk("idle_done_md", mw_memData, 16'h0);
    chk("idle_done_wb", mw_wbData, 16'h4321);
    set_xm(1'b1, 1'b0, 16'h0060, 16'h0000, 1'b1, 3'd2, 16'h0000, 1'b0);
    tick();
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    chk("rm_stall", stall, 1'b0);
    chk("rm_req", mem_req, 1'b0);
    chk("rm_err", err, 1'b0);
    chk("rm_addr", mem_addr, 16'h0);
    chk("rm_wr", mem_wr, 1'b0);
    chk_mw("rm", 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk); idle_inputs(); rst = 1'b1;
    r0 = req_seen;
    repeat (3) tick();
    chk("rm_no_req", req_seen - r0, 0);
    chk("rm_idle_stall", stall, 1'b0);
    set_xm(1'b1, 1'b0, 16'h0062, 16'h0000, 1'b1, 3'd3, 16'h0000, 1'b0);
    @(negedge clk);
    chk("rm_new_req", mem_req, 1'b1);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h2468;
    @(negedge clk);
    tick();
    idle_inputs();
    chk("rm_ld_data", mw_memData, 16'h2468);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
